// File: rtl/sequence_detector_pkg.sv
// Shared definitions for the "1001" serial sequence detector.
package sequence_detector_pkg;

    // Serial pattern, oldest bit in the MSB.
    localparam logic [3:0] PATTERN = 4'b1001;

    // Width of the saturating detection counter.
    localparam int CNT_W = 8;

    // FSM states; each names the longest useful prefix seen so far.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_1    = 3'd1,
        S_10   = 3'd2,
        S_100  = 3'd3,
        S_DET  = 3'd4
    } state_e;

endpackage

// File: rtl/sequence_detector_sat_counter.sv
// Up-counter that holds at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: step by one when enabled, unless already at the ceiling.
    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sequence_detector.sv
// Moore FSM detecting the serial pattern 1,0,0,1 on X with overlap, plus a
// saturating count of detections.
module sequence_detector
    import sequence_detector_pkg::*;
(
    input  logic             CLK,
    input  logic             RST,
    input  logic             X,
    output logic             Y,
    output logic [CNT_W-1:0] CNT
);

    state_e state_q;
    state_e state_d;
    logic   det_next;

    // Next-state logic. Fallback targets on a mismatching bit reflect the
    // self-overlap of "1001": a stray 1 is always a fresh "1" prefix, and
    // after a match the final 1 starts the next attempt.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = (X == PATTERN[3]) ? S_1   : S_IDLE;
            S_1:     state_d = (X == PATTERN[2]) ? S_10  : S_1;
            S_10:    state_d = (X == PATTERN[1]) ? S_100 : S_1;
            S_100:   state_d = (X == PATTERN[0]) ? S_DET : S_IDLE;
            S_DET:   state_d = (X == PATTERN[2]) ? S_10  : S_1;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset discards any partial match immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode from the registered state only (Moore); unused
    // encodings decode to 0.
    always_comb begin
        Y = (state_q == S_DET);
    end

    // Count on the same edge that enters S_DET, so CNT moves with Y.
    assign det_next = (state_d == S_DET);

    sat_counter #(
        .W(CNT_W)
    ) u_sat_counter (
        .clk   (CLK),
        .rst   (RST),
        .inc_en(det_next),
        .count (CNT)
    );

endmodule

// File: tb/tb_sequence_detector.sv
// Self-checking bench for sequence_detector. The reference model keeps the
// history of bits sampled since reset and flags a detect whenever the last
// four samples read 1,0,0,1.
module tb_sequence_detector;

    logic       CLK;
    logic       RST;
    logic       X;
    logic       Y;
    logic [7:0] CNT;

    int checks;
    int errors;

    // Reference model state
    logic [3:0] hist;
    int         nvalid;
    logic       y_m;
    int         cnt_m;

    sequence_detector dut (
        .CLK(CLK),
        .RST(RST),
        .X  (X),
        .Y  (Y),
        .CNT(CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_clear();
        hist   = 4'b0000;
        nvalid = 0;
        y_m    = 1'b0;
        cnt_m  = 0;
    endtask

    // Drive one bit, let one rising edge sample it, update the model and
    // return 1 ns after the edge.
    task automatic step(input logic x);
        X = x;
        @(posedge CLK);
        #1;
        if (RST) begin
            model_clear();
        end else begin
            hist = {hist[2:0], x};
            if (nvalid < 4) nvalid++;
            y_m = (nvalid >= 4) && (hist == 4'b1001);
            if (y_m && cnt_m < 255) cnt_m++;
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(1'b0);
        step(1'b1);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        X   = 1'b0;
        model_clear();
        #2;
        checks++;
        if (Y !== 1'b0 || CNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_async Y=%b CNT=%0d want Y=0 CNT=0", Y, CNT);
        end
        for (int i = 0; i < 4; i++) begin
            step(i[0]);
            checks++;
            if (Y !== 1'b0 || CNT !== 8'd0) begin
                errors++;
                $display("FAIL reset_hold i=%0d Y=%b CNT=%0d want Y=0 CNT=0", i, Y, CNT);
            end
        end
        RST = 1'b0;
    endtask

    task automatic test_directed_16();
        logic [15:0] seq;
        seq = 16'b0001110010011110;
        do_reset();
        for (int i = 15; i >= 0; i--) begin
            step(seq[i]);
            checks++;
            if (Y !== y_m || CNT !== cnt_m[7:0]) begin
                errors++;
                $display("FAIL directed16 sample=%0d Y=%b CNT=%0d want Y=%b CNT=%0d",
                         16 - i, Y, CNT, y_m, cnt_m);
            end
            checks++;
            if (Y !== ((16 - i == 9) || (16 - i == 12))) begin
                errors++;
                $display("FAIL directed16_pos sample=%0d Y=%b", 16 - i, Y);
            end
        end
        checks++;
        if (CNT !== 8'd2) begin
            errors++;
            $display("FAIL directed16_cnt CNT=%0d want 2", CNT);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] seq;
        seq = 7'b1001001;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            step(seq[i]);
            checks++;
            if (Y !== ((7 - i == 4) || (7 - i == 7)) || Y !== y_m) begin
                errors++;
                $display("FAIL overlap sample=%0d Y=%b want %b", 7 - i, Y, y_m);
            end
        end
        checks++;
        if (CNT !== 8'd2) begin
            errors++;
            $display("FAIL overlap_cnt CNT=%0d want 2", CNT);
        end
    endtask

    task automatic test_restart_101();
        logic [5:0] seq;
        seq = 6'b101001;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            step(seq[i]);
            checks++;
            if (Y !== (i == 0) || CNT !== cnt_m[7:0]) begin
                errors++;
                $display("FAIL restart101 sample=%0d Y=%b CNT=%0d want Y=%b CNT=%0d",
                         6 - i, Y, CNT, (i == 0), cnt_m);
            end
        end
    endtask

    // Reset asserted between edges must clear CNT and the partial match
    // without waiting for a clock edge.
    task automatic test_async_mid_pattern();
        do_reset();
        step(1'b1); step(1'b0); step(1'b0); step(1'b1);
        checks++;
        if (Y !== 1'b1 || CNT !== 8'd1) begin
            errors++;
            $display("FAIL async_pre Y=%b CNT=%0d want Y=1 CNT=1", Y, CNT);
        end
        step(1'b0); step(1'b0);
        #2 RST = 1'b1;
        model_clear();
        #1;
        checks++;
        if (Y !== 1'b0 || CNT !== 8'd0) begin
            errors++;
            $display("FAIL async_assert Y=%b CNT=%0d want Y=0 CNT=0", Y, CNT);
        end
        #1 RST = 1'b0;
        step(1'b1);
        checks++;
        if (Y !== 1'b0 || CNT !== 8'd0) begin
            errors++;
            $display("FAIL async_after Y=%b CNT=%0d want Y=0 CNT=0", Y, CNT);
        end
        step(1'b1);
        checks++;
        if (Y !== 1'b0 || CNT !== 8'd0) begin
            errors++;
            $display("FAIL async_after2 Y=%b CNT=%0d want Y=0 CNT=0", Y, CNT);
        end
        // Reset while Y is high drops Y at once.
        step(1'b0); step(1'b0); step(1'b1);
        #2 RST = 1'b1;
        model_clear();
        #1;
        checks++;
        if (Y !== 1'b0 || CNT !== 8'd0) begin
            errors++;
            $display("FAIL async_y_high Y=%b CNT=%0d want Y=0 CNT=0", Y, CNT);
        end
        #1 RST = 1'b0;
    endtask

    task automatic test_long_runs();
        do_reset();
        for (int i = 0; i < 40; i++) begin
            step(i < 20 ? 1'b1 : 1'b0);
            checks++;
            if (Y !== 1'b0 || CNT !== 8'd0) begin
                errors++;
                $display("FAIL long_runs i=%0d Y=%b CNT=%0d want Y=0 CNT=0", i, Y, CNT);
            end
        end
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        do_reset();
        step(1'b1);
        for (int i = 0; i < 300; i++) begin
            step(1'b0); step(1'b0); step(1'b1);
            if (Y === 1'b1) pulses++;
            checks++;
            if (Y !== y_m || CNT !== cnt_m[7:0]) begin
                errors++;
                $display("FAIL saturation rep=%0d Y=%b CNT=%0d want Y=%b CNT=%0d",
                         i, Y, CNT, y_m, cnt_m);
            end
        end
        checks++;
        if (CNT !== 8'd255 || pulses != 300) begin
            errors++;
            $display("FAIL saturation_end CNT=%0d pulses=%0d want CNT=255 pulses=300", CNT, pulses);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            RST = ($urandom_range(0, 199) == 0);
            step(1'($urandom_range(0, 99) < 55));
            checks++;
            if (Y !== y_m || CNT !== cnt_m[7:0]) begin
                errors++;
                $display("FAIL random i=%0d Y=%b CNT=%0d want Y=%b CNT=%0d",
                         i, Y, CNT, y_m, cnt_m);
            end
        end
        RST = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RST    = 1'b0;
        X      = 1'b0;
        model_clear();
        test_reset();
        test_directed_16();
        test_overlap();
        test_restart_101();
        test_async_mid_pattern();
        test_long_runs();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_detector.md
SEQUENCE_DETECTOR -- requirements
Module: sequence_detector

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 X  input  1  serial data bit, sampled on each CLK rising edge.
REQ-005 Y  output  1  detect flag; high for exactly one cycle after "1001" completes.
REQ-006 CNT  output  8  number of detections since reset; saturates at 255.

Function
REQ-007 The block SHALL detect the serial pattern 1,0,0,1 (oldest bit first) on X, with overlap allowed.
REQ-008 The block SHALL be a Moore FSM; Y SHALL be decoded from the state register only, with no combinational path from X to Y.
REQ-009 The FSM SHALL have these states:
- S_IDLE: no useful prefix
- S_1: seen "1"
- S_10: seen "10"
- S_100: seen "100"
- S_DET: seen "1001"
REQ-010 Transitions (X=0 / X=1):
- S_IDLE -> S_IDLE / S_1
- S_1 -> S_10 / S_1
- S_10 -> S_100 / S_1
- S_100 -> S_IDLE / S_DET
- S_DET -> S_10 / S_1
REQ-011 Y SHALL be 1 only in S_DET.
REQ-012 Latency: Y SHALL rise on the same CLK edge that samples the final 1 of the pattern, and SHALL stay high for one cycle unless the pattern completes again.
REQ-013 The overlap rule SHALL be as follows: the final 1 of a match SHALL serve as the first 1 of the next match, so "1001001" produces two Y pulses, three cycles apart.
REQ-014 CNT SHALL increment by 1 on each CLK edge where the next state is S_DET.
REQ-015 CNT SHALL hold at 8'hFF once reached and SHALL never wrap.
REQ-016 CNT SHALL change on the same edge that Y rises.
REQ-017 Unused state encodings SHALL transition to S_IDLE on the next edge, and Y SHALL be 0 while the FSM is in any of them.
REQ-018 Long runs of 1s SHALL stay in S_1, and long runs of 0s SHALL stay in S_IDLE; neither SHALL produce a false detect.

Reset
REQ-019 While RST=1, the state SHALL be S_IDLE, Y SHALL be 0 and CNT SHALL be 0, independent of CLK.
REQ-020 Reset assertion mid-pattern SHALL discard any partial match.
REQ-021 After RST deasserts, the first X sample taken SHALL be the one on the first rising edge of CLK.
REQ-022 Deassertion of RST SHALL be synchronised externally.

Structure
REQ-023 A shared package SHALL hold:
- the state enum (3-bit encoding): S_IDLE=0, S_1=1, S_10=2, S_100=3, S_DET=4
- the pattern constant PATTERN=4'b1001
- the counter width CNT_W=8
REQ-024 The saturating counter SHALL be one sub-module named sat_counter, with inputs clock, reset and increment enable, and a count output.
REQ-025 The top level SHALL contain the FSM state register, the next-state logic, the output decode and the sat_counter instance.

Verification
REQ-026 Hold RST=1 for 2 cycles while toggling X -> Y=0 and CNT=0 throughout.
REQ-027 After reset, apply X per edge: 0,0,0,1,1,1,0,0,1,0,0,1,1,1,1,0 -> Y high only after the 9th and 12th samples; CNT ends at 2.
REQ-028 Apply X=1,0,0,1,0,0,1 -> two Y pulses, 3 cycles apart (overlap); CNT=2.
REQ-029 Apply X=1,0,1,0,0,1 -> a single Y pulse after the 6th sample (the "101" restart is handled correctly).
REQ-030 Apply X=1,0,0, then assert RST asynchronously between edges, release it, then apply 1 -> no Y pulse; CNT=0.
REQ-031 Repeat "1001" 300 times (overlapped, i.e. the period-3 sequence 100) -> CNT saturates at 255 and Y keeps pulsing.
